// File: rtl/writeback_arbiter_if.sv
// ----------------------------------------------------------------------------
// writeback_arbiter_if: producer, issue and register-file write-port bundle
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface writeback_arbiter_if;
  logic        alu_valid;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;

  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;

  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_addr;
  logic [31:0] md_data;

  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic [31:0] pending;

  logic        reg_write_en;
  logic [4:0]  reg_write_addr;
  logic [31:0] reg_write_data;

  // Producer / pipeline side
  modport master (
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    output md_valid, md_addr, md_data,
    output issue_valid, issue_addr,
    input  mem_ready, md_ready, pending,
    input  reg_write_en, reg_write_addr, reg_write_data
  );

  // Arbiter side
  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    input  md_valid, md_addr, md_data,
    input  issue_valid, issue_addr,
    output mem_ready, md_ready, pending,
    output reg_write_en, reg_write_addr, reg_write_data
  );
endinterface

`default_nettype wire

// File: rtl/writeback_arbiter.sv
// ----------------------------------------------------------------------------
// writeback_arbiter: serialises ALU/load/mul-div results into one RF write port
// and tracks outstanding register writes. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module writeback_arbiter (
  input  logic                clk,
  input  logic                rst,
  writeback_arbiter_if.slave  bus
);

  typedef enum logic {
    GRANT_MEM = 1'b0,
    GRANT_MD  = 1'b1
  } grant_e;

  grant_e      last_grant_q, last_grant_d;
  logic        reg_write_en_q, reg_write_en_d;
  logic [4:0]  reg_write_addr_q, reg_write_addr_d;
  logic [31:0] reg_write_data_q, reg_write_data_d;
  logic [31:0] pending_q, pending_d;

  logic        mem_ready, md_ready;
  logic        win;
  logic [4:0]  win_addr;
  logic [31:0] win_data;

  // ALU is never back-pressured, so it simply masks both handshaked producers.
  always_comb begin
    mem_ready = 1'b0;
    md_ready  = 1'b0;
    if (rst && !bus.alu_valid) begin
      mem_ready = bus.mem_valid && (!bus.md_valid || last_grant_q == GRANT_MD);
      md_ready  = bus.md_valid  && (!bus.mem_valid || last_grant_q == GRANT_MEM);
    end
  end

  always_comb begin
    win      = 1'b0;
    win_addr = 5'd0;
    win_data = 32'd0;
    if (bus.alu_valid) begin
      win      = 1'b1;
      win_addr = bus.alu_addr;
      win_data = bus.alu_data;
    end else if (mem_ready) begin
      win      = 1'b1;
      win_addr = bus.mem_addr;
      win_data = bus.mem_data;
    end else if (md_ready) begin
      win      = 1'b1;
      win_addr = bus.md_addr;
      win_data = bus.md_data;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (mem_ready) begin
      last_grant_d = GRANT_MEM;
    end else if (md_ready) begin
      last_grant_d = GRANT_MD;
    end

    reg_write_en_d   = win && (win_addr != 5'd0);
    reg_write_addr_d = win ? win_addr : reg_write_addr_q;
    reg_write_data_d = win ? win_data : reg_write_data_q;
  end

  // Set is applied after clear so a re-issue to a committing register stays pending.
  always_comb begin
    pending_d = pending_q;
    if (reg_write_en_q) begin
      pending_d[reg_write_addr_q] = 1'b0;
    end
    if (bus.issue_valid && (bus.issue_addr != 5'd0)) begin
      pending_d[bus.issue_addr] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q     <= GRANT_MD;
      reg_write_en_q   <= 1'b0;
      reg_write_addr_q <= 5'd0;
      reg_write_data_q <= 32'd0;
      pending_q        <= 32'd0;
    end else begin
      last_grant_q     <= last_grant_d;
      reg_write_en_q   <= reg_write_en_d;
      reg_write_addr_q <= reg_write_addr_d;
      reg_write_data_q <= reg_write_data_d;
      pending_q        <= pending_d;
    end
  end

  assign bus.mem_ready      = mem_ready;
  assign bus.md_ready       = md_ready;
  assign bus.pending        = pending_q;
  assign bus.reg_write_en   = reg_write_en_q;
  assign bus.reg_write_addr = reg_write_addr_q;
  assign bus.reg_write_data = reg_write_data_q;

endmodule

`default_nettype wire
